// File: rtl/bridge_utils_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bridge_utils (package)
// Description : Shared types and constants for the AXI2APB bridge beat
//               address sequencer and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package bridge_utils;

    // AXI bursts may never cross this boundary
    localparam int BOUNDARY_4K = 4096;

    // Default bridge geometry, used to size the beat_info_t record
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_ID_WIDTH   = 4;
    localparam int DEF_LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } agen_state_t;

    // One emitted beat as seen by the engine
    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_LEN_WIDTH-1:0]  idx;
        logic                      last;
        logic                      err;
    } beat_info_t;

endpackage
`default_nettype wire

// File: rtl/bridge_next_addr.sv
`default_nettype none
// ============================================================================
// Module      : bridge_next_addr
// Description : Combinational next-beat address for FIXED/INCR/WRAP bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module bridge_next_addr
    import bridge_utils::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] cur,
    input  logic [ADDR_WIDTH-1:0] lower,
    input  logic [ADDR_WIDTH-1:0] wsize,
    input  logic [2:0]            size,
    input  burst_t                burst,
    output logic [ADDR_WIDTH-1:0] next
);

    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] stepped;

    // Step to the next aligned beat; WRAP folds back to the window base
    always_comb begin
        bytes   = ADDR_WIDTH'(1) << size;
        stepped = (cur & ~(bytes - ADDR_WIDTH'(1))) + bytes;
        next    = cur;
        case (burst)
            INCR:    next = stepped;
            WRAP:    next = (stepped == lower + wsize) ? lower : stepped;
            default: next = cur;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bridge_beat_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : bridge_beat_addr_gen
// Description : Accepts one AXI burst descriptor and emits one APB-beat
//               address per handshake, with protocol checking and abort.
// Revision    : 1.0 - initial release
// ============================================================================
module bridge_beat_addr_gen
    import bridge_utils::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic [ID_WIDTH-1:0]   beat_id,
    output logic [LEN_WIDTH-1:0]  beat_idx,
    output logic                  beat_last,
    output logic                  beat_err,
    input  logic                  abort,
    output logic                  busy
);

    localparam int MAX_SIZE  = $clog2(DATA_WIDTH / 8);
    // Wide enough that the 4KB check never wraps around the address space
    localparam int XW        = ADDR_WIDTH + LEN_WIDTH + 8;
    localparam int PAGE_BITS = $clog2(BOUNDARY_4K);

    agen_state_t           state, state_next;
    logic [ADDR_WIDTH-1:0] cur_addr, lower_addr, wrap_size, next_addr;
    logic [LEN_WIDTH-1:0]  len_q, idx_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [2:0]            size_q;
    burst_t                burst_q, step_burst;
    logic                  err_q;

    logic                  cmd_fire, beat_fire;
    burst_t                acc_burst;
    logic [ADDR_WIDTH-1:0] acc_bytes, acc_wsize, acc_lower;
    logic [XW-1:0]         ext_start, ext_last;
    logic                  wrap_len_ok, acc_err;

    assign busy       = (state == RUN);
    assign beat_valid = (state == RUN);
    assign cmd_ready  = rst_n && (state == IDLE) && !abort;
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign beat_fire  = beat_valid && beat_ready && !abort;
    assign beat_last  = beat_valid && (idx_q == len_q);
    assign beat_addr  = cur_addr;
    assign beat_id    = id_q;
    assign beat_idx   = idx_q;
    assign beat_err   = err_q;

    // Descriptor decode and legality check, evaluated at acceptance
    always_comb begin
        acc_burst   = burst_t'(cmd_burst);
        acc_bytes   = ADDR_WIDTH'(1) << cmd_size;
        acc_wsize   = (ADDR_WIDTH'(cmd_len) + ADDR_WIDTH'(1)) << cmd_size;
        acc_lower   = cmd_addr & ~(acc_wsize - ADDR_WIDTH'(1));
        ext_start   = XW'(cmd_addr);
        ext_last    = XW'(cmd_addr & ~(acc_bytes - ADDR_WIDTH'(1)))
                    + ((XW'(cmd_len) + XW'(1)) << cmd_size) - XW'(1);
        wrap_len_ok = (cmd_len == LEN_WIDTH'(1)) || (cmd_len == LEN_WIDTH'(3)) ||
                      (cmd_len == LEN_WIDTH'(7)) || (cmd_len == LEN_WIDTH'(15));
        acc_err     = 1'b0;
        if (int'(cmd_size) > MAX_SIZE)
            acc_err = 1'b1;
        if (acc_burst == RSVD)
            acc_err = 1'b1;
        if ((acc_burst == WRAP) &&
            (!wrap_len_ok || ((cmd_addr & (acc_bytes - ADDR_WIDTH'(1))) != '0)))
            acc_err = 1'b1;
        if ((acc_burst == INCR) &&
            (ext_start[XW-1:PAGE_BITS] != ext_last[XW-1:PAGE_BITS]))
            acc_err = 1'b1;
    end

    // Errored bursts repeat the start address on every beat
    assign step_burst = err_q ? FIXED : burst_q;

    bridge_next_addr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_next_addr (
        .cur   (cur_addr),
        .lower (lower_addr),
        .wsize (wrap_size),
        .size  (size_q),
        .burst (step_burst),
        .next  (next_addr)
    );

    // Next-state logic: abort wins over a coincident beat handshake
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_fire) state_next = RUN;
            RUN:     if (abort || (beat_fire && beat_last)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Burst context capture and per-beat advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_addr   <= '0;
            lower_addr <= '0;
            wrap_size  <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            id_q       <= '0;
            size_q     <= '0;
            burst_q    <= FIXED;
            err_q      <= 1'b0;
        end else if (cmd_fire) begin
            cur_addr   <= cmd_addr;
            lower_addr <= acc_lower;
            wrap_size  <= acc_wsize;
            len_q      <= cmd_len;
            idx_q      <= '0;
            id_q       <= cmd_id;
            size_q     <= cmd_size;
            burst_q    <= acc_burst;
            err_q      <= acc_err;
        end else if (beat_fire && !beat_last) begin
            cur_addr   <= next_addr;
            idx_q      <= idx_q + LEN_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bridge_beat_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_bridge_beat_addr_gen
// Description : Scoreboard bench for bridge_beat_addr_gen: directed and
//               random descriptors against a reference burst model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bridge_beat_addr_gen;
    import bridge_utils::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_id = '0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [2:0]  cmd_size = '0;
    logic [1:0]  cmd_burst = '0;
    logic        beat_valid;
    logic        beat_ready = 1'b0;
    logic [31:0] beat_addr;
    logic [3:0]  beat_id;
    logic [7:0]  beat_idx;
    logic        beat_last;
    logic        beat_err;
    logic        abort = 1'b0;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int ready_mode = 1;   // 0 random, 1 always high, 2 always low
    beat_info_t exp_q[$];

    always #5 clk = ~clk;

    bridge_beat_addr_gen #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .ID_WIDTH (4), .LEN_WIDTH (8)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_id (cmd_id),
        .cmd_addr (cmd_addr), .cmd_len (cmd_len), .cmd_size (cmd_size),
        .cmd_burst (cmd_burst),
        .beat_valid (beat_valid), .beat_ready (beat_ready),
        .beat_addr (beat_addr), .beat_id (beat_id), .beat_idx (beat_idx),
        .beat_last (beat_last), .beat_err (beat_err),
        .abort (abort), .busy (busy)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: expand a descriptor into its expected beats
    function automatic void push_burst(logic [3:0] id, logic [31:0] addr,
                                       logic [7:0] len, logic [2:0] size,
                                       logic [1:0] burst);
        longint unsigned bytes, beats, a, aligned, wsize, lower, total, room;
        logic err;
        beat_info_t b;
        bytes   = 64'd1 << size;
        beats   = 64'(len) + 1;
        a       = 64'(addr);
        aligned = a - (a % bytes);
        wsize   = bytes * beats;
        lower   = a - (a % wsize);
        total   = aligned + beats * bytes - a;
        room    = 64'd4096 - (a % 64'd4096);
        err     = (size > 3'd2) || (burst == 2'b11);
        if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) err = 1'b1;
        if (burst == 2'b10 && (a % bytes) != 0) err = 1'b1;
        if (burst == 2'b01 && total > room) err = 1'b1;
        for (int k = 0; k <= int'(len); k++) begin
            longint unsigned ea;
            if (err || burst == 2'b00)  ea = a;
            else if (burst == 2'b01)    ea = (k == 0) ? a : aligned + 64'(k) * bytes;
            else                        ea = lower + ((a - lower) + 64'(k) * bytes) % wsize;
            b.addr = ea[31:0];
            b.id   = id;
            b.idx  = 8'(k);
            b.last = (k == int'(len));
            b.err  = err;
            exp_q.push_back(b);
        end
    endfunction

    // Beat-ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       beat_ready = ($urandom_range(0, 99) < 70);
                1:       beat_ready = 1'b1;
                default: beat_ready = 1'b0;
            endcase
        end
    end

    // Monitor: handshake checks, hold stability and scoreboard pops
    logic       hold_prev = 1'b0;
    beat_info_t snap;
    always @(negedge clk) begin
        beat_info_t e;
        if (!rst_n) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            chk("cmd_ready_rule", 64'(cmd_ready), 64'(!busy && !abort));
            chk("busy_vs_valid", 64'(busy), 64'(beat_valid));
            if (hold_prev) begin
                chk("hold_valid", 64'(beat_valid), 64'd1);
                chk("hold_addr",  64'(beat_addr), 64'(snap.addr));
                chk("hold_idx",   64'(beat_idx),  64'(snap.idx));
                chk("hold_last",  64'(beat_last), 64'(snap.last));
                chk("hold_err",   64'(beat_err),  64'(snap.err));
            end
            if (abort) begin
                if (busy) exp_q.delete();
            end else if (beat_valid && beat_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(beat_addr), 64'hDEAD_BEEF_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_addr", 64'(beat_addr), 64'(e.addr));
                    chk("beat_id",   64'(beat_id),   64'(e.id));
                    chk("beat_idx",  64'(beat_idx),  64'(e.idx));
                    chk("beat_last", 64'(beat_last), 64'(e.last));
                    chk("beat_err",  64'(beat_err),  64'(e.err));
                end
            end
            hold_prev = beat_valid && !beat_ready && !abort;
            snap = '{beat_addr, beat_id, beat_idx, beat_last, beat_err};
        end
    end

    task automatic send_cmd(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
        int waited = 0;
        bit ok = 0;
        @(posedge clk);
        #1;
        cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
        cmd_valid = 1'b1;
        while (!ok && waited < 500) begin
            @(negedge clk);
            if (cmd_ready) begin
                push_burst(id, addr, len, size, burst);
                ok = 1;
            end
            @(posedge clk);
            #1;
            waited++;
        end
        cmd_valid = 1'b0;
        if (!ok) chk("cmd_accept_timeout", 64'd0, 64'd1);
        else begin
            @(negedge clk);
            chk("beat0_latency", 64'(beat_valid), 64'd1);
        end
    endtask

    task automatic wait_idle();
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while ((exp_q.size() != 0 || busy) && waited < 3000);
        if (waited >= 3000) chk("idle_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready",  64'(cmd_ready),  64'd0);
        chk("rst_beat_valid", 64'(beat_valid), 64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_beat_addr",  64'(beat_addr),  64'd0);
        chk("rst_beat_fields", 64'({beat_id, beat_idx, beat_last, beat_err}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(cmd_ready), 64'd1);

        // Directed bursts
        ready_mode = 1;
        send_cmd(4'h1, 32'h0000_1000, 8'd3, 3'd2, 2'b01);
        wait_idle();
        chk("ready_after_burst", 64'(cmd_ready), 64'd1);
        send_cmd(4'h2, 32'h0000_1002, 8'd2, 3'd2, 2'b01);
        send_cmd(4'h3, 32'h0000_1038, 8'd3, 3'd2, 2'b10);
        send_cmd(4'h4, 32'h0000_2000, 8'd2, 3'd2, 2'b00);
        send_cmd(4'h5, 32'h0000_1040, 8'd2, 3'd2, 2'b10);
        send_cmd(4'h6, 32'h0000_0FF8, 8'd3, 3'd2, 2'b01);
        send_cmd(4'h7, 32'h0000_3000, 8'd1, 3'd3, 2'b01);
        send_cmd(4'h8, 32'h0000_3100, 8'd0, 3'd1, 2'b11);
        wait_idle();

        // Backpressure: outputs must freeze while ready is low
        ready_mode = 2;
        send_cmd(4'h9, 32'h0000_4000, 8'd3, 3'd2, 2'b01);
        repeat (5) @(negedge clk);
        chk("bp_idx_frozen", 64'(beat_idx), 64'd0);
        chk("bp_valid_held", 64'(beat_valid), 64'd1);
        ready_mode = 1;
        wait_idle();

        // Abort coincident with the beat 2 handshake
        send_cmd(4'hA, 32'h0000_5000, 8'd5, 3'd2, 2'b01);
        begin
            int w = 0;
            while (beat_idx != 8'd1 && w < 50) begin
                @(negedge clk);
                w++;
            end
            chk("abort_reach_beat1", 64'(beat_idx), 64'd1);
        end
        @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        chk("abort_at_beat2", 64'(beat_idx), 64'd2);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_valid_low", 64'(beat_valid), 64'd0);
        chk("abort_busy_low",  64'(busy),       64'd0);
        chk("abort_ready",     64'(cmd_ready),  64'd1);
        send_cmd(4'hB, 32'h0000_6000, 8'd0, 3'd2, 2'b01);
        wait_idle();

        // Abort in IDLE blocks acceptance
        @(posedge clk);
        #1 abort = 1'b1;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("idle_abort_blocks", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1 abort = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("idle_abort_no_start", 64'(busy), 64'd0);

        // Reset in the middle of a burst
        send_cmd(4'hC, 32'h0000_7000, 8'd7, 3'd2, 2'b01);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_valid", 64'(beat_valid), 64'd0);
        chk("midrst_busy",  64'(busy),       64'd0);
        chk("midrst_addr",  64'(beat_addr),  64'd0);
        chk("midrst_fields", 64'({beat_id, beat_idx, beat_last, beat_err}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized descriptors with random backpressure
        ready_mode = 0;
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, mask;
            logic [2:0]  sz;
            logic [1:0]  bt;
            logic [7:0]  ln;
            a  = $urandom;
            sz = 3'($urandom_range(0, 3));
            bt = 2'($urandom_range(0, 3));
            ln = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = {a[31:12], 12'hFC0} | 32'($urandom_range(0, 63));
            mask = (32'd1 << sz) - 32'd1;
            if (bt == 2'b10 && $urandom_range(0, 3) != 0) a = a & ~mask;
            send_cmd(4'($urandom_range(0, 15)), a, ln, sz, bt);
        end
        ready_mode = 1;
        wait_idle();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
